pipe_stage_reg: RTL and testbench

Parametrised, elastic pipeline-stage register for the MIPS datapath (EX/MEM by default, reusable at any stage boundary). Carries a control field that is cleared when a bubble is inserted and a data field that is only ever overwritten by new data. Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure never has a combinational path from `out_ready` to `in_ready`. Also adds a synchronous flush and a saturating stall counter for performance debug.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_slot.sv | 35 +++
 rtl/pipe_stage_reg.sv | 61 ++++++
 tb/tb_pipe_stage_reg.sv | 139 +++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: stage-boundary widths and field offsets shared by the pipeline registers
// Exports EX/MEM, ID/EX and MEM/WB ctrl/data widths plus EX/MEM field LSB positions.
package pipe_pkg;
   localparam int EX_MEM_CTRL_W = 5;
   localparam int EX_MEM_DATA_W = 77;
   localparam int WB_LSB = 3;
   localparam int WB_W = 2;
   localparam int MEM_LSB = 0;
   localparam int MEM_W = 3;
   localparam int REGDST_LSB = 0;
   localparam int REGDST_W = 5;
   localparam int WDATA_LSB = 5;
   localparam int WDATA_W = 32;
   localparam int ALU_RES_LSB = 37;
   localparam int ALU_RES_W = 32;
   localparam int ALU_STAT_LSB = 69;
   localparam int ALU_STAT_W = 8;
   localparam int ID_EX_CTRL_W = 9;
   localparam int ID_EX_DATA_W = 106;
   localparam int MEM_WB_CTRL_W = 2;
   localparam int MEM_WB_DATA_W = 69;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid+ctrl+data entry of an elastic stage register
// Ports: clk, rst_n (sync, active-low), flush/clear drop the entry (ctrl zeroed,
// data kept), load captures d_ctrl/d_data; valid/ctrl/data are the held entry.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int CTRL_W = EX_MEM_CTRL_W,
   parameter int DATA_W = EX_MEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
      end else if (flush || clear) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= d_ctrl;
         data  <= d_data;
      end
   end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline-stage register with 2-entry skid buffer
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready/in_ctrl/in_data upstream,
// flush kills held beats, out_valid/out_ready/out_ctrl/out_data downstream,
// occupancy = beats held, stall_cnt = saturating count of stalled output cycles.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = EX_MEM_CTRL_W,
   parameter int DATA_W = EX_MEM_DATA_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);
   logic              m_valid, s_valid;
   logic [CTRL_W-1:0] m_ctrl, s_ctrl;
   logic [DATA_W-1:0] m_data, s_data;
   logic              accept, m_free;
   // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally
   assign in_ready  = ~s_valid;
   assign accept    = in_valid & ~s_valid;
   assign m_free    = ~m_valid | out_ready;
   assign out_valid = m_valid;
   assign out_ctrl  = m_ctrl;
   assign out_data  = m_data;
   // S is only ever valid while M is valid, so the sum fits in two bits this way
   assign occupancy = {m_valid & s_valid, m_valid ^ s_valid};
   // S drains into M ahead of any new input to keep beats in order
   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_m (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .load(m_free & (s_valid | accept)),
      .clear(m_free & ~s_valid & ~accept),
      .d_ctrl(s_valid ? s_ctrl : in_ctrl),
      .d_data(s_valid ? s_data : in_data),
      .valid(m_valid), .ctrl(m_ctrl), .data(m_data)
   );
   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_s (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .load(~m_free & accept),
      .clear(m_free & s_valid),
      .d_ctrl(in_ctrl), .d_data(in_data),
      .valid(s_valid), .ctrl(s_ctrl), .data(s_data)
   );
   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (m_valid && !out_ready && !(&stall_cnt))
         stall_cnt <= stall_cnt + 1'b1;
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized + directed scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;
   localparam int CW = 5;
   localparam int DW = 77;
   localparam int NW = 3;
   localparam logic [NW-1:0] CMAX = '1;
   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } beat_t;
   logic          clk = 1'b0;
   logic          rst_n, in_valid, in_ready, flush, out_valid, out_ready;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [DW-1:0] in_data, out_data;
   logic [1:0]    occupancy;
   logic [NW-1:0] stall_cnt;
   beat_t         q[$];
   logic [DW-1:0] last_d;
   logic [NW-1:0] e_cnt;
   bit            chk_en, acc;
   int            total, bad;
   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall_cnt)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask
   // Reference model: q holds beats in arrival order, head is what the stage presents.
   // At each negedge the outputs are compared, then the inputs (stable until the next
   // posedge) advance the model across the coming edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", out_valid, q.size() != 0);
         if (q.size() != 0) begin
            chk("out_ctrl", out_ctrl, q[0].c);
            chk("out_data", out_data, q[0].d);
            last_d = q[0].d;
         end else begin
            chk("out_ctrl_bubble", out_ctrl, 0);
            chk("out_data_hold", out_data, last_d);
         end
         chk("in_ready", in_ready, q.size() < 2);
         chk("occupancy", occupancy, q.size());
         chk("stall_cnt", stall_cnt, e_cnt);
      end
      if (!rst_n) begin
         q.delete();
         last_d = '0;
         e_cnt = '0;
      end else begin
         if (q.size() != 0 && !out_ready && e_cnt != CMAX) e_cnt++;
         if (flush) q.delete();
         else begin
            acc = in_valid && q.size() < 2;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back('{c: in_ctrl, d: in_data});
         end
      end
   end
   function automatic logic [DW-1:0] rd();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[DW-1:0];
   endfunction
   task automatic drive(input bit iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input bit ordy, input bit fl);
      in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
      @(posedge clk);
      #2;
   endtask
   task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d, input bit ordy);
      bit took;
      for (int n = 0; n < 50; n++) begin
         took = q.size() < 2;
         drive(1'b1, c, d, ordy, 1'b0);
         if (took) return;
      end
      total++;
      bad++;
      $display("FAIL send_timeout: beat %h not accepted within 50 cycles", d);
   endtask
   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, ordy, 1'b0);
   endtask
   initial begin
      total = 0; bad = 0; chk_en = 0;
      rst_n = 1'b0; in_valid = 0; in_ctrl = '0; in_data = '0; out_ready = 0; flush = 0;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      chk_en = 1;
      // stream with out_ready held high, then a bubble
      send(5'h1F, 77'h1_2345_6789_ABCD_EF01_00, 1'b1);
      for (int i = 1; i < 4; i++) send(5'(i), rd(), 1'b1);
      idle(3, 1'b1);
      // back-pressure: A, B absorbed, C held upstream while the counter saturates
      send(5'h0A, rd(), 1'b0);
      send(5'h0B, rd(), 1'b0);
      begin
         logic [DW-1:0] cd;
         cd = rd();
         for (int i = 0; i < 10; i++) drive(1'b1, 5'h0C, cd, 1'b0, 1'b0);
         send(5'h0C, cd, 1'b1);
      end
      idle(3, 1'b1);
      // flush with both slots full and a beat on the input
      send(5'h11, rd(), 1'b0);
      send(5'h12, rd(), 1'b0);
      drive(1'b1, 5'h13, rd(), 1'b0, 1'b1);
      idle(3, 1'b1);
      // reset mid-operation with a full stage and stall_cnt at 5
      rst_n = 1'b0;
      idle(1, 1'b0);
      rst_n = 1'b1;
      send(5'h15, rd(), 1'b0);
      send(5'h16, rd(), 1'b0);
      for (int i = 0; i < 20 && e_cnt != 5; i++) idle(1, 1'b0);
      chk("stall_reaches_5", stall_cnt, 5);
      rst_n = 1'b0;
      drive(1'b1, 5'h17, rd(), 1'b0, 1'b0);
      rst_n = 1'b1;
      send(5'h18, rd(), 1'b1);
      idle(2, 1'b1);
      // random traffic with occasional flushes
      for (int i = 0; i < 400; i++)
         drive(1'($urandom_range(0, 1)), 5'($urandom), rd(), $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0);
      idle(4, 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
